// File: rtl/fence_t_sequencer_pkg.sv
// fence_t_sequencer_pkg
//   Shared types for the fence.t temporal-fence sequencer: the sequencer
//   state, the pad-source selector and the privilege encodings that the
//   pad trigger logic compares against.
package fence_t_sequencer_pkg;

  // Sequencer phases, in the order one fence.t walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    DRAIN = 3'd2,
    PAD   = 3'd3,
    RST   = 3'd4
  } fence_t_state_e;

  // Event that (re)starts the pad counter. PAD_RSVD behaves like PAD_NONE.
  typedef enum logic [1:0] {
    PAD_TIMER = 2'd0,
    PAD_UMODE = 2'd1,
    PAD_NONE  = 2'd2,
    PAD_RSVD  = 2'd3
  } fence_t_pad_src_e;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Pad sources that skip the PAD phase entirely.
  function automatic logic pad_skipped(fence_t_pad_src_e src);
    return (src == PAD_NONE) || (src == PAD_RSVD);
  endfunction

endpackage

// File: rtl/fence_t_sequencer_counter.sv
// fence_t_sequencer_counter
//   Generic up/down counter with synchronous clear and load.
//   Priority: clear > load > count. Counting wraps; callers gate en_i to
//   get saturation.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset (count -> 0)
//   clear_i        force count to 0
//   load_i, d_i    load d_i
//   en_i, down_i   step by one, downwards when down_i
//   q_o            current count
module fence_t_sequencer_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  input  logic             en_i,
  input  logic             down_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      q_o <= '0;
    else if (clear_i) q_o <= '0;
    else if (load_i)  q_o <= d_i;
    else if (en_i)    q_o <= down_i ? q_o - Width'(1) : q_o + Width'(1);
  end

endmodule

// File: rtl/fence_t_sequencer.sv
// fence_t_sequencer
//   Runs the fence.t temporal fence: dcache flush, drain of all handshaked
//   memory ports, optional time padding, a microarchitectural reset pulse
//   and a cache re-init suppression window. Captures the resume PC.
//   rst_uarch_no must never be routed back into this block's rst_ni,
//   otherwise the sequencer would reset itself out of RST.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   fence_t_i, pc_commit_i committed fence.t pulse and its PC
//   boot_addr_i            reset vector, shown on rst_addr_o until a capture
//   rst_addr_o             fetch address after the microreset
//   flush_dcache_o/_ack_i  dcache flush handshake
//   flush_icache_o         icache flush pulse, same cycle as acceptance
//   busy_i                 per-port outstanding-transaction flags
//   pad_i, pad_src_i       pad length and the event that starts it
//   time_irq_i, priv_lvl_i raw inputs for the pad trigger events
//   ceil_clr_i, ceil_o     clear / read the largest pre-pad execution time
//   halt_o, stall_cache_o  high whenever a fence is in progress
//   rst_uarch_no           microarchitectural reset, active low
//   cache_init_no          cache init suppression window
module fence_t_sequencer
  import fence_t_sequencer_pkg::*;
#(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned NrDrainPorts    = 2,
  parameter int unsigned DrainIdleCycles = 16,
  parameter int unsigned RstUarchCycles  = 16,
  parameter int unsigned CacheInitCycles = 3,
  parameter int unsigned PadWidth        = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fence_t_i,
  input  logic [VLEN-1:0]         pc_commit_i,
  input  logic [VLEN-1:0]         boot_addr_i,
  output logic [VLEN-1:0]         rst_addr_o,
  output logic                    flush_dcache_o,
  input  logic                    flush_dcache_ack_i,
  output logic                    flush_icache_o,
  input  logic [NrDrainPorts-1:0] busy_i,
  input  logic [PadWidth-1:0]     pad_i,
  input  logic [1:0]              pad_src_i,
  input  logic                    time_irq_i,
  input  logic [1:0]              priv_lvl_i,
  input  logic                    ceil_clr_i,
  output logic [PadWidth-1:0]     ceil_o,
  output logic                    halt_o,
  output logic                    stall_cache_o,
  output logic                    rst_uarch_no,
  output logic                    cache_init_no
);

  localparam int unsigned         DrainW   = $clog2(DrainIdleCycles);
  localparam logic [DrainW-1:0]   DrainMax = DrainW'(DrainIdleCycles - 1);
  // +1 keeps the width non-zero when the pulse is a single cycle.
  localparam int unsigned         RstW     = $clog2(RstUarchCycles + 1);
  localparam logic [RstW-1:0]     RstLast  = RstW'(RstUarchCycles - 1);

  fence_t_state_e             state_q, state_d;
  fence_t_pad_src_e           pad_src;
  logic [DrainW-1:0]          drain_cnt;
  logic [PadWidth-1:0]        pad_cnt, pad_cand, ceil_q;
  logic [RstW-1:0]            rst_cnt_q, rst_cnt_d;
  logic [CacheInitCycles-1:0] init_pipe;
  logic [VLEN-1:0]            rst_addr_q;
  logic                       rst_addr_vld_q;
  logic [1:0]                 priv_q;
  logic                       irq_q;
  logic                       rst_uarch_q;
  logic                       accept, drain_done, pad_load, pad_zero;

  assign pad_src    = fence_t_pad_src_e'(pad_src_i);
  assign accept     = (state_q == IDLE) && fence_t_i;
  assign drain_done = (state_q == DRAIN) && (drain_cnt == DrainMax);
  assign pad_zero   = (pad_cnt == '0);

  // Pad trigger: timer irq rising edge, or leaving U-mode.
  assign pad_load = ((pad_src == PAD_TIMER) && time_irq_i && !irq_q) ||
                    ((pad_src == PAD_UMODE) && (priv_q == PRIV_U) &&
                     (priv_lvl_i != PRIV_U));

  // Execution time already spent since the pad event when the drain ends.
  assign pad_cand = pad_zero ? '0 : pad_i - pad_cnt;

  // Consecutive all-idle cycles; free-running, saturating.
  fence_t_sequencer_counter #(.Width(DrainW)) i_drain_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (|busy_i),
    .load_i  (1'b0),
    .d_i     ('0),
    .en_i    (drain_cnt != DrainMax),
    .down_i  (1'b0),
    .q_o     (drain_cnt)
  );

  // Remaining pad cycles; free-running, reloads on every trigger event.
  fence_t_sequencer_counter #(.Width(PadWidth)) i_pad_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (1'b0),
    .load_i  (pad_load),
    .d_i     (pad_i),
    .en_i    (!pad_zero),
    .down_i  (1'b1),
    .q_o     (pad_cnt)
  );

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = '0;
    flush_icache_o = accept;
    flush_dcache_o = (state_q == FLUSH);
    halt_o         = (state_q != IDLE);
    stall_cache_o  = (state_q != IDLE);
    unique case (state_q)
      IDLE:  if (fence_t_i) state_d = FLUSH;
      FLUSH: if (flush_dcache_ack_i) state_d = DRAIN;
      DRAIN: if (drain_done) state_d = pad_skipped(pad_src) ? RST : PAD;
      PAD:   if (pad_zero) state_d = RST;
      RST: begin
        if (rst_cnt_q == RstLast) state_d = IDLE;
        else rst_cnt_d = rst_cnt_q + RstW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rst_cnt_q      <= '0;
      rst_uarch_q    <= 1'b1;
      init_pipe      <= '0;
      rst_addr_q     <= '0;
      rst_addr_vld_q <= 1'b0;
      ceil_q         <= '0;
      priv_q         <= PRIV_M;
      irq_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      // Registered so the reset line is a clean flop output; timing equals
      // a decode of state_q == RST.
      rst_uarch_q <= (state_d != RST);
      priv_q      <= priv_lvl_i;
      irq_q       <= time_irq_i;
      init_pipe[0] <= (state_q == RST);
      for (int i = 1; i < CacheInitCycles; i++) init_pipe[i] <= init_pipe[i-1];
      if (accept) begin
        rst_addr_q     <= pc_commit_i + VLEN'(4);
        rst_addr_vld_q <= 1'b1;
      end
      // A clear that lands on the drain exit keeps the fresh sample.
      if (ceil_clr_i)                         ceil_q <= drain_done ? pad_cand : '0;
      else if (drain_done && pad_cand > ceil_q) ceil_q <= pad_cand;
    end
  end

  // Until the first capture the resume address is the reset vector.
  assign rst_addr_o    = rst_addr_vld_q ? rst_addr_q : boot_addr_i;
  assign ceil_o        = ceil_q;
  assign rst_uarch_no  = rst_uarch_q;
  assign cache_init_no = |init_pipe;

endmodule

// File: tb/tb_fence_t_sequencer.sv
module tb_fence_t_sequencer;

  localparam int DRAIN_N = 16;
  localparam int RST_N   = 16;
  localparam int INIT_N  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fence_t, ack, irq, ceil_clr;
  logic [63:0] pc, boot, rst_addr;
  logic [1:0]  busy, pad_src, priv;
  logic [31:0] pad, ceil;
  logic        fl_dc, fl_ic, halt, stall, rst_uarch_n, init_n;

  always #5 clk = ~clk;

  fence_t_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .fence_t_i          (fence_t),
    .pc_commit_i        (pc),
    .boot_addr_i        (boot),
    .rst_addr_o         (rst_addr),
    .flush_dcache_o     (fl_dc),
    .flush_dcache_ack_i (ack),
    .flush_icache_o     (fl_ic),
    .busy_i             (busy),
    .pad_i              (pad),
    .pad_src_i          (pad_src),
    .time_irq_i         (irq),
    .priv_lvl_i         (priv),
    .ceil_clr_i         (ceil_clr),
    .ceil_o             (ceil),
    .halt_o             (halt),
    .stall_cache_o      (stall),
    .rst_uarch_no       (rst_uarch_n),
    .cache_init_no      (init_n)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 flush, 2 drain, 3 pad, 4 reset pulse
  int          m_phase, m_idle, m_rst_done;
  longint      m_cyc, m_load_cyc, m_load_val, m_init_lo, m_init_hi;
  bit          m_loaded, m_prev_irq;
  logic [1:0]  m_prev_priv;
  logic [63:0] m_addr;
  logic [31:0] m_ceil;

  function automatic longint pad_left();
    longint v;
    if (!m_loaded) return 0;
    v = m_load_val - (m_cyc - m_load_cyc - 1);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idle = 0; m_rst_done = 0; m_loaded = 0;
    m_prev_irq = 0; m_prev_priv = 2'b11;
    m_addr = boot; m_ceil = '0;
    m_init_lo = -1; m_init_hi = -2;
  endtask

  task automatic model_step();
    longint      pl;
    logic [31:0] cand;
    bit          ev, dexit;
    int          nxt;
    pl    = pad_left();
    cand  = (pl == 0) ? 32'd0 : pad - 32'(pl);
    ev    = (pad_src == 2'd0 && irq && !m_prev_irq) ||
            (pad_src == 2'd1 && m_prev_priv == 2'b00 && priv != 2'b00);
    dexit = (m_phase == 2) && (m_idle >= DRAIN_N - 1);
    if (ceil_clr) m_ceil = dexit ? cand : 32'd0;
    else if (dexit && cand > m_ceil) m_ceil = cand;
    nxt = m_phase;
    case (m_phase)
      0: if (fence_t) begin nxt = 1; m_addr = pc + 64'd4; end
      1: if (ack) nxt = 2;
      2: if (dexit) nxt = (pad_src >= 2) ? 4 : 3;
      3: if (pl == 0) nxt = 4;
      default: begin m_rst_done++; if (m_rst_done == RST_N) nxt = 0; end
    endcase
    if (nxt == 4 && m_phase != 4) begin
      m_rst_done = 0;
      m_init_lo  = m_cyc + 2;
      m_init_hi  = m_cyc + 1 + RST_N + INIT_N - 1;
    end
    m_phase = nxt;
    m_idle  = (busy != 0) ? 0 : m_idle + 1;
    if (ev) begin m_loaded = 1; m_load_cyc = m_cyc; m_load_val = longint'(pad); end
    m_prev_irq = irq; m_prev_priv = priv;
    m_cyc++;
  endtask

  // ---------------- run-length trackers ----------------
  int rl = 0, il = 0, hl = 0, dl = 0, last_hl = 0, last_dl = 0;

  task automatic cyc();
    logic [5:0] e;
    @(negedge clk);
    e = {(m_phase == 0) && fence_t, m_phase == 1, m_phase != 0, m_phase != 0,
         m_phase != 4, (m_cyc >= m_init_lo) && (m_cyc <= m_init_hi)};
    chk("ctl", 64'({fl_ic, fl_dc, halt, stall, rst_uarch_n, init_n}), 64'(e));
    chk("rst_addr", rst_addr, m_addr);
    chk("ceil", 64'(ceil), 64'(m_ceil));
    if (!rst_uarch_n) rl++; else begin if (rl != 0) chk("rst_len", 64'(rl), 64'(RST_N)); rl = 0; end
    if (init_n) il++; else begin if (il != 0) chk("init_len", 64'(il), 64'(RST_N + INIT_N - 1)); il = 0; end
    if (halt) hl++; else begin if (hl != 0) last_hl = hl; hl = 0; end
    if (fl_dc) dl++; else begin if (dl != 0) last_dl = dl; dl = 0; end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    fence_t = 0; ack = 0; ceil_clr = 0;
    rst_n = 0;
    #1;
    chk("rst_ctl", 64'({fl_ic, fl_dc, halt, stall, rst_uarch_n, init_n}), 64'(6'b000010));
    chk("rst_addr_boot", rst_addr, boot);
    chk("rst_ceil", 64'(ceil), 64'd0);
    model_reset();
    rl = 0; il = 0; hl = 0; dl = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (halt !== 1'b0 && n < 400) begin cyc(); n++; end
    if (n >= 400) chk("idle_timeout", 64'(halt), 64'd0);
  endtask

  // Timer edge, then a fence whose drain exit is 'cand+1' cycles after the edge.
  task automatic timed_fence(input int cand);
    irq = 0; cyc();
    irq = 1; cyc();
    repeat (cand - 2) cyc();
    fence_t = 1; cyc(); fence_t = 0;
    ack = 1; cyc(); ack = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1; fence_t = 0; ack = 0; irq = 0; ceil_clr = 0;
    pc = '0; boot = 64'h0000_0000_0001_0000; busy = '0;
    pad_src = 2'd2; priv = 2'b11; pad = '0; m_cyc = 0;
    #2;
    do_reset();

    // 1: basic flow, no padding
    repeat (20) cyc();
    pc = 64'h8000_1000; fence_t = 1; cyc(); fence_t = 0;
    repeat (4) cyc();
    ack = 1; cyc(); ack = 0;
    wait_idle(); repeat (5) cyc();
    chk("s1_addr", rst_addr, 64'h8000_1004);
    chk("s1_dcache_len", 64'(last_dl), 64'd5);
    chk("s1_halt_len", 64'(last_hl), 64'd22);

    // 2: drain restart on busy pulse
    fence_t = 1; cyc(); fence_t = 0;
    ack = 1; busy = 2'b10; cyc(); ack = 0;
    repeat (6) cyc();
    busy = 2'b00; repeat (7) cyc();
    busy = 2'b01; cyc(); busy = 2'b00;
    wait_idle(); repeat (3) cyc();
    chk("s2_halt_len", 64'(last_hl), 64'd47);

    // 3: timer padding and ceil
    ceil_clr = 1; cyc(); ceil_clr = 0;
    pad_src = 2'd0; pad = 32'd100;
    timed_fence(40); wait_idle(); repeat (3) cyc();
    chk("s3_ceil", 64'(ceil), 64'd40);
    chk("s3_halt_len", 64'(last_hl), 64'd78);
    timed_fence(25); wait_idle(); repeat (3) cyc();
    chk("s3_ceil_keep", 64'(ceil), 64'd40);
    timed_fence(25);
    ceil_clr = 1; cyc(); ceil_clr = 0;
    chk("s3_clr_at_exit", 64'(ceil), 64'd25);
    wait_idle();
    ceil_clr = 1; cyc(); ceil_clr = 0;
    chk("s3_ceil_clr", 64'(ceil), 64'd0);

    // 4: leaving U-mode during FLUSH, then no event at all
    pad_src = 2'd1; pad = 32'd50; priv = 2'b00; repeat (3) cyc();
    fence_t = 1; cyc(); fence_t = 0;
    priv = 2'b01; ack = 1; cyc(); ack = 0;
    wait_idle(); repeat (3) cyc();
    chk("s4_halt_len", 64'(last_hl), 64'd68);
    fence_t = 1; cyc(); fence_t = 0;
    ack = 1; cyc(); ack = 0;
    wait_idle(); repeat (3) cyc();
    chk("s4_early_len", 64'(last_hl), 64'd19);
    chk("s4_ceil", 64'(ceil), 64'd0);

    // 5: fence.t ignored in PAD, then reset mid-RST
    pad_src = 2'd0; pad = 32'd60; pc = 64'hA000_0000;
    timed_fence(20); repeat (6) cyc();
    pc = 64'hB000_0000; fence_t = 1; cyc(); fence_t = 0;
    chk("s5_addr_hold", rst_addr, 64'hA000_0004);
    n = 0;
    while (rst_uarch_n !== 1'b0 && n < 200) begin cyc(); n++; end
    if (n >= 200) chk("s5_rst_timeout", 64'(rst_uarch_n), 64'd0);
    repeat (3) cyc();
    do_reset();

    // randomized traffic, with pc wrap and occasional async reset
    for (int i = 0; i < 5000; i++) begin
      fence_t  = ($urandom % 12 == 0);
      pc       = ($urandom % 8 == 0) ? ~64'd0 - 64'($urandom_range(0, 7)) : {$urandom, $urandom};
      ack      = ($urandom % 4 == 0);
      busy     = {($urandom % 16 == 0), ($urandom % 16 == 0)};
      ceil_clr = ($urandom % 80 == 0);
      if ($urandom % 50 == 0) pad_src = 2'($urandom % 4);
      if ($urandom % 30 == 0) pad = $urandom % 60;
      if ($urandom % 15 == 0) irq = ~irq;
      if ($urandom % 20 == 0) begin
        case ($urandom % 3)
          0: priv = 2'b00;
          1: priv = 2'b01;
          default: priv = 2'b11;
        endcase
      end
      cyc();
      if (i % 1700 == 1699) do_reset();
    end
    fence_t = 0; ack = 0; busy = '0; ceil_clr = 0;
    wait_idle(); repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
